// File: rtl/prog_seq_pkg.sv
// Shared types for the programmable sequencer: entry modes, the jump-table
// entry record and the top-level state encoding.
package prog_seq_pkg;

    // Entry fields are sized for the largest supported sequencer (16 states, 32-bit dwell).
    localparam int MAX_SW    = 4;
    localparam int MAX_CNT_W = 32;

    typedef logic [1:0] seq_mode_t;

    localparam seq_mode_t MODE_WAIT   = 2'b00;
    localparam seq_mode_t MODE_DWELL  = 2'b01;
    localparam seq_mode_t MODE_TERM   = 2'b10;
    localparam seq_mode_t MODE_BRANCH = 2'b11;

    typedef logic [0:0] top_state_t;

    localparam top_state_t ST_IDLE = 1'b0;
    localparam top_state_t ST_RUN  = 1'b1;

    typedef struct packed {
        logic [MAX_SW-1:0]    target;
        seq_mode_t            mode;
        logic [MAX_CNT_W-1:0] count;
    } seq_entry_t;

endpackage

// File: rtl/prog_seq_table.sv
// Jump-table register file: one {target, mode, count} entry per sequence state,
// guarded writes with a one-cycle error pulse, and a sanitised read port.
module prog_seq_table
    import prog_seq_pkg::*;
#(
    parameter int N_STATES = 8,
    parameter int CNT_W    = 8,
    parameter int SW       = $clog2(N_STATES)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_allow,
    input  logic             cfg_we,
    input  logic [SW-1:0]    cfg_addr,
    input  logic [SW-1:0]    cfg_target,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic [SW-1:0]    rd_addr,
    output seq_entry_t       rd_entry,
    output logic             cfg_err
);

    localparam logic [SW:0] N_VAL = N_STATES[SW:0];

    logic [SW-1:0]    tgt_q  [N_STATES];
    seq_mode_t        mode_q [N_STATES];
    logic [CNT_W-1:0] cnt_q  [N_STATES];

    logic          addr_ok;
    logic          wr_ok;
    logic [SW-1:0] raw_tgt;
    logic [SW-1:0] safe_tgt;

    assign addr_ok = ({1'b0, cfg_addr} < N_VAL);
    assign wr_ok   = wr_allow & addr_ok;

    // Reset rebuilds the default ring 0 -> 1 -> ... -> N-1 -> 0, all WAIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_STATES; i++) begin
                tgt_q[i]  <= SW'((i + 1) % N_STATES);
                mode_q[i] <= MODE_WAIT;
                cnt_q[i]  <= '0;
            end
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we & ~wr_ok;
            if (cfg_we && wr_ok) begin
                tgt_q[cfg_addr]  <= cfg_target;
                mode_q[cfg_addr] <= cfg_mode;
                cnt_q[cfg_addr]  <= cfg_count;
            end
        end
    end

    // A stored target outside the state range is folded to state 0.
    assign raw_tgt  = tgt_q[rd_addr];
    assign safe_tgt = ({1'b0, raw_tgt} < N_VAL) ? raw_tgt : '0;

    always_comb begin
        rd_entry        = '0;
        rd_entry.target = MAX_SW'(safe_tgt);
        rd_entry.mode   = mode_q[rd_addr];
        rd_entry.count  = MAX_CNT_W'(cnt_q[rd_addr]);
    end

endmodule

// File: rtl/prog_seq_fsm.sv
// Programmable sequencer: walks a jump table from state 0, each state advancing
// on its condition bit, a dwell timeout, a branch, or terminating back to IDLE.
module prog_seq_fsm
    import prog_seq_pkg::*;
#(
    parameter int N_STATES = 8,
    parameter int CNT_W    = 8,
    localparam int SW      = $clog2(N_STATES)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                ok,
    input  logic                halt,
    input  logic [N_STATES-1:0] in,
    input  logic                cfg_we,
    input  logic [SW-1:0]       cfg_addr,
    input  logic [SW-1:0]       cfg_target,
    input  logic [1:0]          cfg_mode,
    input  logic [CNT_W-1:0]    cfg_count,
    output logic [N_STATES-1:0] out,
    output logic [SW-1:0]       state_idx,
    output logic                running,
    output logic                done,
    output logic                cfg_err
);

    localparam logic [N_STATES-1:0] ONE  = {{(N_STATES - 1){1'b0}}, 1'b1};
    localparam logic [SW-1:0]       LAST = SW'(N_STATES - 1);

    top_state_t          state_q, state_n;
    logic [SW-1:0]       cur_q, cur_n;
    logic [CNT_W-1:0]    dwell_q, dwell_n;
    logic [N_STATES-1:0] out_n;
    logic                done_n;
    logic                reenter;

    seq_entry_t          entry;
    logic [SW-1:0]       tgt;
    logic [SW-1:0]       cur_inc;
    logic                cond;

    prog_seq_table #(
        .N_STATES (N_STATES),
        .CNT_W    (CNT_W),
        .SW       (SW)
    ) u_table (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_allow   (state_q == ST_IDLE),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_target (cfg_target),
        .cfg_mode   (cfg_mode),
        .cfg_count  (cfg_count),
        .rd_addr    (cur_q),
        .rd_entry   (entry),
        .cfg_err    (cfg_err)
    );

    assign tgt     = entry.target[SW-1:0];
    assign cond    = in[cur_q];
    assign cur_inc = (cur_q == LAST) ? '0 : cur_q + 1'b1;

    // Every taken transition, including a jump to the same state, re-enters it.
    always_comb begin
        state_n = state_q;
        cur_n   = cur_q;
        done_n  = 1'b0;
        reenter = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ok) begin
                    state_n = ST_RUN;
                    cur_n   = '0;
                    reenter = 1'b1;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    state_n = ST_IDLE;
                    cur_n   = '0;
                end else begin
                    case (entry.mode)
                        MODE_WAIT: begin
                            if (cond) begin
                                cur_n   = tgt;
                                reenter = 1'b1;
                            end
                        end
                        MODE_DWELL: begin
                            if (dwell_q == entry.count[CNT_W-1:0]) begin
                                cur_n   = tgt;
                                reenter = 1'b1;
                            end
                        end
                        MODE_TERM: begin
                            if (cond) begin
                                state_n = ST_IDLE;
                                cur_n   = '0;
                                done_n  = 1'b1;
                            end
                        end
                        default: begin
                            cur_n   = cond ? tgt : cur_inc;
                            reenter = 1'b1;
                        end
                    endcase
                end
            end
            default: begin
                state_n = ST_IDLE;
                cur_n   = '0;
            end
        endcase
    end

    always_comb begin
        dwell_n = '0;
        if (state_n == ST_RUN && !reenter) begin
            dwell_n = (entry.mode == MODE_DWELL) ? dwell_q + 1'b1 : dwell_q;
        end
        out_n = (state_n == ST_RUN) ? (ONE << cur_n) : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            dwell_q <= '0;
            out     <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_n;
            cur_q   <= cur_n;
            dwell_q <= dwell_n;
            out     <= out_n;
            done    <= done_n;
        end
    end

    assign running   = (state_q == ST_RUN);
    assign state_idx = cur_q;

endmodule
